// File: rtl/paillier_pkg.sv
// Shared command encodings, FSM state encodings and small decode helpers
// for the Paillier task sequencer.
package paillier_pkg;

  localparam logic [2:0] CMD_LOAD_N = 3'b000;
  localparam logic [2:0] CMD_ENC    = 3'b001;
  localparam logic [2:0] CMD_HADD   = 3'b010;
  localparam logic [2:0] CMD_SMUL   = 3'b011;
  localparam logic [2:0] CMD_RAW_ME = 3'b100;

  typedef enum logic [2:0] {
    PC_LOAD_N = CMD_LOAD_N,
    PC_ENC    = CMD_ENC,
    PC_HADD   = CMD_HADD,
    PC_SMUL   = CMD_SMUL,
    PC_RAW_ME = CMD_RAW_ME
  } paillier_cmd_e;

  localparam logic [2:0] S_IDLE            = 3'd0;
  localparam logic [2:0] S_LOAD            = 3'd1;
  localparam logic [2:0] S_ISSUE           = 3'd2;
  localparam logic [2:0] S_COLLECT         = 3'd3;
  localparam logic [2:0] S_COMBINE_ISSUE   = 3'd4;
  localparam logic [2:0] S_COMBINE_COLLECT = 3'd5;
  localparam logic [2:0] S_DRAIN           = 3'd6;

  typedef enum logic [2:0] {
    PS_IDLE            = S_IDLE,
    PS_LOAD            = S_LOAD,
    PS_ISSUE           = S_ISSUE,
    PS_COLLECT         = S_COLLECT,
    PS_COMBINE_ISSUE   = S_COMBINE_ISSUE,
    PS_COMBINE_COLLECT = S_COMBINE_COLLECT,
    PS_DRAIN           = S_DRAIN
  } paillier_state_e;

  function automatic logic cmd_uses_me(input logic [2:0] c);
    return (c == CMD_ENC) || (c == CMD_SMUL) || (c == CMD_RAW_ME);
  endfunction

  function automatic logic cmd_uses_mm(input logic [2:0] c);
    return (c == CMD_ENC) || (c == CMD_HADD);
  endfunction

endpackage

// File: rtl/paillier_limb_buf.sv
// N x K limb register buffer: one synchronous write port, one combinational
// read port. Contents are intentionally not reset.
module paillier_limb_buf #(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [K-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [K-1:0]  rdata
);

  logic [K-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/paillier_task_seq.sv
// Paillier task sequencer: streams operand limbs to external ME/MM engines,
// gathers their results and drains the final limbs. Optional cycle counter
// enabled by defining PAILLIER_SEQ_PERF_EN.
module paillier_task_seq
  import paillier_pkg::*;
#(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] task_cmd,
  input  logic          task_req,
  output logic          task_busy,
  output logic          task_end,
  output logic          task_err,
  input  logic [K-1:0]  in_a_data,
  input  logic [K-1:0]  in_b_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [K-1:0]  out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic          me_start,
  output logic          me_x_valid,
  output logic          me_y_valid,
  output logic [K-1:0]  me_x,
  output logic [K-1:0]  me_y,
  input  logic [K-1:0]  me_result,
  input  logic          me_valid,
  output logic          mm_start,
  output logic          mm_x_valid,
  output logic          mm_y_valid,
  output logic [K-1:0]  mm_x,
  output logic [K-1:0]  mm_y,
  input  logic [K-1:0]  mm_result,
  input  logic          mm_valid,
  output logic [2:0]    dbg_state
`ifdef PAILLIER_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  // Handshakes: a limb moves on the rising edge where valid && ready are both
  // high; a source holding valid keeps its data stable until that edge. The
  // engine x/y streams have no ready: every valid beat is taken by the engine.

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [2:0]    state;
  logic [2:0]    cmd_q;
  logic          n_loaded;
  logic [AW-1:0] in_idx, out_idx, me_idx, mm_idx;
  logic          me_done, mm_done;
  logic          carry;

  logic          cmd_ok, accept, reject;
  logic          uses_me, uses_mm;
  logic          in_fire, collecting, combining, me_take, mm_take;
  logic [K:0]    mm_sum;
  logic [AW-1:0] rd_idx;
  logic [K-1:0]  nbuf_rd, buf0_rd, buf1_rd;
  logic          buf0_we;
  logic [AW-1:0] buf0_waddr;
  logic [K-1:0]  buf0_wdata;

  assign cmd_ok = (task_cmd <= CW'(CMD_RAW_ME)) &&
                  !((task_cmd == CW'(CMD_ENC)) && !n_loaded);
  assign accept = (state == S_IDLE) && task_req && cmd_ok;
  assign reject = (state == S_IDLE) && task_req && !cmd_ok;

  assign uses_me    = cmd_uses_me(cmd_q);
  assign uses_mm    = cmd_uses_mm(cmd_q);
  assign in_ready   = (state == S_LOAD) || (state == S_ISSUE);
  assign in_fire    = in_valid && in_ready;
  assign collecting = (state == S_ISSUE) || (state == S_COLLECT);
  assign combining  = (state == S_COMBINE_ISSUE) || (state == S_COMBINE_COLLECT);
  assign me_take    = collecting && uses_me && me_valid && !me_done;
  assign mm_take    = (collecting || combining) && uses_mm && mm_valid && !mm_done;

  // Adds the "+1" of g^m = 1 + m*n; carry starts at 1 only for ENC.
  assign mm_sum = {1'b0, mm_result} + {{K{1'b0}}, carry};

  assign rd_idx     = (state == S_DRAIN) ? out_idx : in_idx;
  assign buf0_we    = me_take || (combining && mm_take);
  assign buf0_waddr = combining ? mm_idx : me_idx;
  assign buf0_wdata = combining ? mm_result : me_result;

  assign out_valid = (state == S_DRAIN);
  assign out_last  = out_valid && (out_idx == LAST);
  assign out_data  = out_valid ? ((cmd_q == CMD_HADD) ? buf1_rd : buf0_rd) : '0;
  assign dbg_state = state;

  paillier_limb_buf #(.K(K), .N(N), .AW(AW)) u_nbuf (
    .clk(clk), .we((state == S_LOAD) && in_fire), .waddr(in_idx),
    .wdata(in_a_data), .raddr(in_idx), .rdata(nbuf_rd)
  );

  paillier_limb_buf #(.K(K), .N(N), .AW(AW)) u_buf0 (
    .clk(clk), .we(buf0_we), .waddr(buf0_waddr),
    .wdata(buf0_wdata), .raddr(rd_idx), .rdata(buf0_rd)
  );

  paillier_limb_buf #(.K(K), .N(N), .AW(AW)) u_buf1 (
    .clk(clk), .we(collecting && mm_take), .waddr(mm_idx),
    .wdata(mm_sum[K-1:0]), .raddr(rd_idx), .rdata(buf1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_q      <= CMD_LOAD_N;
      n_loaded   <= 1'b0;
      in_idx     <= '0;
      out_idx    <= '0;
      me_idx     <= '0;
      mm_idx     <= '0;
      me_done    <= 1'b0;
      mm_done    <= 1'b0;
      carry      <= 1'b0;
      task_busy  <= 1'b0;
      task_end   <= 1'b0;
      task_err   <= 1'b0;
      me_start   <= 1'b0;
      me_x_valid <= 1'b0;
      me_y_valid <= 1'b0;
      me_x       <= '0;
      me_y       <= '0;
      mm_start   <= 1'b0;
      mm_x_valid <= 1'b0;
      mm_y_valid <= 1'b0;
      mm_x       <= '0;
      mm_y       <= '0;
    end else begin
      task_end   <= 1'b0;
      task_err   <= 1'b0;
      me_start   <= 1'b0;
      mm_start   <= 1'b0;
      me_x_valid <= 1'b0;
      me_y_valid <= 1'b0;
      mm_x_valid <= 1'b0;
      mm_y_valid <= 1'b0;

      // Result counters hold at N-1; the done bit marks the final limb.
      if (me_take) begin
        if (me_idx == LAST) me_done <= 1'b1;
        else                me_idx  <= me_idx + AW'(1);
      end
      if (mm_take) begin
        if (mm_idx == LAST) mm_done <= 1'b1;
        else                mm_idx  <= mm_idx + AW'(1);
        if (collecting) carry <= mm_sum[K];
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_q     <= task_cmd[2:0];
            task_busy <= 1'b1;
            in_idx    <= '0;
            out_idx   <= '0;
            me_idx    <= '0;
            mm_idx    <= '0;
            me_done   <= 1'b0;
            mm_done   <= 1'b0;
            carry     <= (task_cmd == CW'(CMD_ENC));
            if (task_cmd == CW'(CMD_LOAD_N)) begin
              state <= S_LOAD;
            end else begin
              state    <= S_ISSUE;
              me_start <= cmd_uses_me(task_cmd[2:0]);
              mm_start <= cmd_uses_mm(task_cmd[2:0]);
            end
          end else if (reject) begin
            task_err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            if (in_idx == LAST) begin
              n_loaded  <= 1'b1;
              task_end  <= 1'b1;
              task_busy <= 1'b0;
              state     <= S_IDLE;
            end else begin
              in_idx <= in_idx + AW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (in_fire) begin
            case (cmd_q)
              CMD_ENC: begin
                me_x <= in_a_data;  me_y <= nbuf_rd;
                mm_x <= nbuf_rd;    mm_y <= in_b_data;
                me_x_valid <= 1'b1; me_y_valid <= 1'b1;
                mm_x_valid <= 1'b1; mm_y_valid <= 1'b1;
              end
              CMD_HADD: begin
                mm_x <= in_a_data;  mm_y <= in_b_data;
                mm_x_valid <= 1'b1; mm_y_valid <= 1'b1;
              end
              default: begin
                me_x <= in_a_data;  me_y <= in_b_data;
                me_x_valid <= 1'b1; me_y_valid <= 1'b1;
              end
            endcase
            if (in_idx == LAST) state  <= S_COLLECT;
            else                in_idx <= in_idx + AW'(1);
          end
        end
        S_COLLECT: begin
          if ((!uses_me || me_done) && (!uses_mm || mm_done)) begin
            if (cmd_q == CMD_ENC) begin
              state    <= S_COMBINE_ISSUE;
              mm_start <= 1'b1;
              in_idx   <= '0;
              mm_idx   <= '0;
              mm_done  <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_COMBINE_ISSUE: begin
          mm_x       <= buf0_rd;
          mm_y       <= buf1_rd;
          mm_x_valid <= 1'b1;
          mm_y_valid <= 1'b1;
          if (in_idx == LAST) state  <= S_COMBINE_COLLECT;
          else                in_idx <= in_idx + AW'(1);
        end
        S_COMBINE_COLLECT: begin
          if (mm_done) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_idx == LAST) begin
              task_end  <= 1'b1;
              task_busy <= 1'b0;
              state     <= S_IDLE;
            end else begin
              out_idx <= out_idx + AW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PAILLIER_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                                 perf_cycles <= '0;
    else if (accept)                         perf_cycles <= '0;
    else if (task_busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_paillier_task_seq.sv
// Directed bench for paillier_task_seq with simple two-stage ME/MM engine
// models (me = x*y+1, mm = x+y, both modulo 2^K).
module tb_paillier_task_seq;
  import paillier_pkg::*;

  localparam int K = 128;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    task_cmd;
  logic          task_req;
  logic          task_busy, task_end, task_err;
  logic [K-1:0]  in_a_data, in_b_data;
  logic          in_valid, in_ready;
  logic [K-1:0]  out_data;
  logic          out_valid, out_last, out_ready;
  logic          me_start, me_x_valid, me_y_valid;
  logic [K-1:0]  me_x, me_y;
  logic [K-1:0]  me_result = '0;
  logic          me_valid = 1'b0;
  logic          mm_start, mm_x_valid, mm_y_valid;
  logic [K-1:0]  mm_x, mm_y;
  logic [K-1:0]  mm_result = '0;
  logic          mm_valid = 1'b0;
  logic [2:0]    dbg_state;
`ifdef PAILLIER_SEQ_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  int total = 0;
  int bad = 0;

  logic [K-1:0] a_vec [N];
  logic [K-1:0] b_vec [N];
  logic [K-1:0] got [N];
  logic         got_last [N];
  logic [K-1:0] exp_q [$];
  int           stall_viol;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  paillier_task_seq #(.K(K), .N(N), .CW(3)) dut (
    .clk(clk), .rst(rst), .task_cmd(task_cmd), .task_req(task_req),
    .task_busy(task_busy), .task_end(task_end), .task_err(task_err),
    .in_a_data(in_a_data), .in_b_data(in_b_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready),
    .me_start(me_start), .me_x_valid(me_x_valid), .me_y_valid(me_y_valid),
    .me_x(me_x), .me_y(me_y), .me_result(me_result), .me_valid(me_valid),
    .mm_start(mm_start), .mm_x_valid(mm_x_valid), .mm_y_valid(mm_y_valid),
    .mm_x(mm_x), .mm_y(mm_y), .mm_result(mm_result), .mm_valid(mm_valid),
    .dbg_state(dbg_state)
`ifdef PAILLIER_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // ---------------- engine models and event monitors ----------------
  logic [K-1:0] me_p1 = '0, mm_p1 = '0;
  logic         me_v1 = 1'b0, mm_v1 = 1'b0;
  int end_cnt = 0, me_start_cnt = 0, mm_start_cnt = 0, busy_hi = 0;

  always @(posedge clk) begin
    me_v1     <= me_x_valid && me_y_valid;
    me_p1     <= me_x * me_y + K'(1);
    me_valid  <= me_v1;
    me_result <= me_p1;
    mm_v1     <= mm_x_valid && mm_y_valid;
    mm_p1     <= mm_x + mm_y;
    mm_valid  <= mm_v1;
    mm_result <= mm_p1;
    if (task_end)  end_cnt      <= end_cnt + 1;
    if (me_start)  me_start_cnt <= me_start_cnt + 1;
    if (mm_start)  mm_start_cnt <= mm_start_cnt + 1;
    if (task_busy) busy_hi      <= busy_hi + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [2:0] c);
    task_cmd = c;
    task_req = 1'b1;
    tick();
    task_req = 1'b0;
  endtask

  task automatic send_ops(output bit ok);
    int i = 0;
    int guard = 0;
    bit fire;
    while (i < N && guard < 2000) begin
      in_valid  = 1'b1;
      in_a_data = a_vec[i];
      in_b_data = b_vec[i];
      fire = in_ready;
      tick();
      guard++;
      if (fire) i++;
    end
    in_valid = 1'b0;
    ok = (i == N);
  endtask

  task automatic recv_out(input bit toggle, output bit ok);
    int n = 0;
    int guard = 0;
    bit stalled = 0;
    logic [K-1:0] held = '0;
    stall_viol = 0;
    while (n < N && guard < 2000) begin
      out_ready = toggle ? guard[0] : 1'b1;
      if (out_valid) begin
        if (stalled && out_data !== held) stall_viol++;
        if (out_ready) begin
          got[n] = out_data;
          got_last[n] = out_last;
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = out_data;
        end
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    ok = (n == N);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({task_busy, task_end, task_err, in_ready, out_valid, out_last} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {task_busy, task_end, task_err, in_ready, out_valid, out_last});
    end
    total++;
    if (out_data !== '0) begin
      bad++; $display("FAIL reset_out_data: got %0h expected 0", out_data);
    end
    total++;
    if ({me_start, me_x_valid, me_y_valid, mm_start, mm_x_valid, mm_y_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_engine_ctrl: got %b expected 000000",
               {me_start, me_x_valid, me_y_valid, mm_start, mm_x_valid, mm_y_valid});
    end
    total++;
    if ({me_x, me_y, mm_x, mm_y} !== '0) begin
      bad++; $display("FAIL reset_engine_data: got nonzero expected 0");
    end
    total++;
    if (dbg_state !== S_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
`ifdef PAILLIER_SEQ_PERF_EN
    total++;
    if (perf_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_perf: got %0d expected 0", perf_cycles);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_err_cmd(input logic [2:0] c, input string name);
    start_cmd(c);
    total++;
    if (task_err !== 1'b1 || task_busy !== 1'b0) begin
      bad++; $display("FAIL %s_err_pulse: got err=%b busy=%b expected err=1 busy=0", name, task_err, task_busy);
    end
    tick();
    total++;
    if (task_err !== 1'b0 || task_busy !== 1'b0 || dbg_state !== S_IDLE) begin
      bad++; $display("FAIL %s_err_after: got err=%b busy=%b state=%0d expected 0 0 0", name, task_err, task_busy, dbg_state);
    end
  endtask

  task automatic test_load_raw_me();
    bit ok;
    int e0, s0, m0;
    for (int i = 0; i < N; i++) begin
      a_vec[i] = K'(i + 1);
      b_vec[i] = K'(32'hdead_0000 + i);
    end
    e0 = end_cnt;
    start_cmd(CMD_LOAD_N);
    total++;
    if (task_busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL load_accept: got busy=%b in_ready=%b expected 1 1", task_busy, in_ready);
    end
    send_ops(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL load_send: got timeout expected %0d beats", N); end
    total++;
    if (task_end !== 1'b1 || task_busy !== 1'b0) begin
      bad++; $display("FAIL load_end: got end=%b busy=%b expected 1 0", task_end, task_busy);
    end
    tick();
    total++;
    if (end_cnt - e0 !== 1) begin
      bad++; $display("FAIL load_end_count: got %0d expected 1", end_cnt - e0);
    end

    for (int i = 0; i < N; i++) begin
      a_vec[i] = '0;
      b_vec[i] = '0;
    end
    a_vec[0] = K'(2);
    b_vec[0] = K'(16);
    exp_q.delete();
    exp_q.push_back(K'(32'h21));
    for (int i = 1; i < N; i++) exp_q.push_back(K'(1));
    e0 = end_cnt; s0 = me_start_cnt; m0 = mm_start_cnt;
    start_cmd(CMD_RAW_ME);
    total++;
    if (me_start !== 1'b1 || mm_start !== 1'b0 || task_busy !== 1'b1) begin
      bad++; $display("FAIL raw_start: got me=%b mm=%b busy=%b expected 1 0 1", me_start, mm_start, task_busy);
    end
    send_ops(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL raw_send: got timeout expected %0d beats", N); end
    recv_out(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL raw_recv: got timeout expected %0d limbs", N); end
    tick();
    for (int i = 0; i < N; i++) begin
      logic [K-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (got[i] !== e || got_last[i] !== (i == N - 1)) begin
        bad++; $display("FAIL raw_limb%0d: got %0h last=%b expected %0h last=%b", i, got[i], got_last[i], e, (i == N - 1));
      end
    end
    total++;
    if (end_cnt - e0 !== 1 || me_start_cnt - s0 !== 1 || mm_start_cnt - m0 !== 0 || task_busy !== 1'b0) begin
      bad++; $display("FAIL raw_events: got end=%0d me_start=%0d mm_start=%0d busy=%b expected 1 1 0 0",
                      end_cnt - e0, me_start_cnt - s0, mm_start_cnt - m0, task_busy);
    end
  endtask

  task automatic test_enc();
    bit ok;
    int e0, s0, m0;
    // n limbs are i+1; b = ~n makes every first-pass mm limb all ones, so
    // the injected carry ripples through and buf1 ends up all zero.
    for (int i = 0; i < N; i++) begin
      a_vec[i] = K'(3);
      b_vec[i] = ~K'(i + 1);
    end
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(K'(3 * (i + 1) + 1));
    e0 = end_cnt; s0 = me_start_cnt; m0 = mm_start_cnt;
    start_cmd(CMD_ENC);
    total++;
    if (me_start !== 1'b1 || mm_start !== 1'b1) begin
      bad++; $display("FAIL enc_start: got me=%b mm=%b expected 1 1", me_start, mm_start);
    end
    send_ops(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL enc_send: got timeout expected %0d beats", N); end
    recv_out(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL enc_recv: got timeout expected %0d limbs", N); end
    tick();
    for (int i = 0; i < N; i++) begin
      logic [K-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin
        bad++; $display("FAIL enc_limb%0d: got %0h expected %0h", i, got[i], e);
      end
    end
    total++;
    if (end_cnt - e0 !== 1 || me_start_cnt - s0 !== 1 || mm_start_cnt - m0 !== 2) begin
      bad++; $display("FAIL enc_events: got end=%0d me_start=%0d mm_start=%0d expected 1 1 2",
                      end_cnt - e0, me_start_cnt - s0, mm_start_cnt - m0);
    end
  endtask

  task automatic test_reset_mid_collect();
    bit ok;
    int e0;
    for (int i = 0; i < N; i++) begin
      a_vec[i] = K'(5);
      b_vec[i] = K'(7);
    end
    start_cmd(CMD_SMUL);
    send_ops(ok);
    total++;
    if (!ok || dbg_state !== S_COLLECT) begin
      bad++; $display("FAIL mid_reach_collect: got ok=%b state=%0d expected 1 %0d", ok, dbg_state, S_COLLECT);
    end
    e0 = end_cnt;
    rst = 1'b1;
    tick();
    total++;
    if ({task_busy, task_end, task_err, in_ready, out_valid, out_last,
         me_start, me_x_valid, me_y_valid, mm_start, mm_x_valid, mm_y_valid} !== 12'b0 ||
        {out_data, me_x, me_y, mm_x, mm_y} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got busy=%b mev=%b expected all zero", task_busy, me_x_valid);
    end
    rst = 1'b0;
    repeat (6) tick();
    total++;
    if (end_cnt !== e0 || task_busy !== 1'b0 || dbg_state !== S_IDLE) begin
      bad++; $display("FAIL mid_reset_abort: got ends=%0d busy=%b state=%0d expected 0 0 0", end_cnt - e0, task_busy, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int e0;
    for (int i = 0; i < N; i++) begin
      a_vec[i] = K'(i + 1);
      b_vec[i] = K'(i) << 8;
    end
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(K'(i + 1 + (i << 8)));
    e0 = end_cnt;
    start_cmd(CMD_HADD);
    send_ops(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hadd_send: got timeout expected %0d beats", N); end
    recv_out(1'b1, ok);
    total++;
    if (!ok || stall_viol !== 0) begin
      bad++; $display("FAIL hadd_stall: got ok=%b unstable=%0d expected 1 0", ok, stall_viol);
    end
    for (int i = 0; i < N; i++) begin
      logic [K-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (got[i] !== e || got_last[i] !== (i == N - 1)) begin
        bad++; $display("FAIL hadd_limb%0d: got %0h last=%b expected %0h", i, got[i], got_last[i], e);
      end
    end

    // Next request issued in the cycle task_end is visible.
    for (int i = 0; i < N; i++) begin
      a_vec[i] = K'(i + 2);
      b_vec[i] = K'(3);
    end
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(K'(3 * (i + 2) + 1));
    start_cmd(CMD_SMUL);
    total++;
    if (task_busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept: got busy=%b expected 1", task_busy);
    end
    send_ops(ok);
    recv_out(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL smul_recv: got timeout expected %0d limbs", N); end
    tick();
    for (int i = 0; i < N; i++) begin
      logic [K-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin
        bad++; $display("FAIL smul_limb%0d: got %0h expected %0h", i, got[i], e);
      end
    end
    total++;
    if (end_cnt - e0 !== 2) begin
      bad++; $display("FAIL b2b_end_count: got %0d expected 2", end_cnt - e0);
    end
  endtask

`ifdef PAILLIER_SEQ_PERF_EN
  task automatic test_perf();
    bit ok;
    int b0;
    for (int i = 0; i < N; i++) begin
      a_vec[i] = K'(i);
      b_vec[i] = K'(1);
    end
    b0 = busy_hi;
    start_cmd(CMD_HADD);
    send_ops(ok);
    recv_out(1'b1, ok);
    repeat (3) tick();
    total++;
    if (perf_cycles !== 32'(busy_hi - b0)) begin
      bad++; $display("FAIL perf_cycles: got %0d expected %0d", perf_cycles, busy_hi - b0);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; task_cmd = '0; task_req = 1'b0;
    in_a_data = '0; in_b_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_err_cmd(CMD_ENC, "enc_before_load");
    test_err_cmd(3'b111, "illegal_111");
    test_err_cmd(3'b101, "illegal_101");
    test_load_raw_me();
    test_enc();
    test_reset_mid_collect();
    test_back_to_back();
`ifdef PAILLIER_SEQ_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
